pcie_msg_transmitter: RTL and testbench

PCIE_MSG_TRANSMITTER -- requirements
Module: pcie_msg_transmitter

---
 rtl/pcie_msg_transmitter.sv | 227 ++++++++++++++++++++++
 tb/tb_pcie_msg_transmitter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msg_transmitter.sv
// Message transmitter: reads a message payload from SRAM and sends it as one or
// more AXI write bursts. Each burst carries a 32-bit header beat followed by up
// to MAX_FRAG_BEATS payload beats. All outputs are registered.
module pcie_msg_transmitter #(
  parameter int unsigned MAX_FRAG_BEATS = 4,
  parameter logic [63:0] AXI_BASE       = 64'h0,
  parameter logic [3:0]  HDR_VER        = 4'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tx_start,
  input  logic [9:0]   tx_base_addr,
  input  logic [10:0]  tx_len,
  input  logic [2:0]   tx_tag,
  input  logic         tx_to,
  input  logic [7:0]   tx_src_id,
  input  logic [7:0]   tx_dst_id,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx_err,
  output logic         sram_ren,
  output logic [9:0]   sram_raddr,
  input  logic [255:0] sram_rdata,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [63:0]  axi_awaddr,
  output logic [7:0]   axi_awlen,
  output logic [2:0]   axi_awsize,
  output logic [1:0]   axi_awburst,
  output logic         axi_wvalid,
  input  logic         axi_wready,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  output logic         axi_wlast,
  input  logic         axi_bvalid,
  input  logic [1:0]   axi_bresp,
  output logic         axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AW    = 3'd1,
    S_HDR   = 3'd2,
    S_RD    = 3'd3,
    S_RWAIT = 3'd4,
    S_WDAT  = 3'd5,
    S_BRESP = 3'd6
  } state_t;

  localparam logic [10:0] MAX_FRAG = 11'(MAX_FRAG_BEATS);

  state_t       state_r, state_next;
  logic [10:0]  remaining_r, rem_next;
  logic [9:0]   addr_r;
  logic [7:0]   beats_left_r;
  logic [1:0]   seq_r;
  logic         first_r;
  logic [2:0]   tag_r;
  logic         to_r;
  logic [7:0]   src_r, dst_r;
  logic [7:0]   frag_next;
  logic         start_ok, start_bad, b_ok, b_bad;
  logic         last_frag;
  logic [31:0]  header;

  // Output registers; axi_wdata doubles as the payload hold register.
  logic         awvalid_r, wvalid_r, wlast_r, bready_r, ren_r, busy_r, done_r, err_r;
  logic [63:0]  awaddr_r;
  logic [7:0]   awlen_r;
  logic [255:0] wdata_r;

  // The current fragment is the last one when what is left fits in one burst.
  assign last_frag = (remaining_r <= MAX_FRAG);
  assign header    = {first_r, last_frag, seq_r, to_r, tag_r, src_r, dst_r, 4'h0, HDR_VER};

  // Next-state logic plus the handshake events that drive the datapath.
  always_comb begin
    state_next = state_r;
    rem_next   = remaining_r;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    b_ok       = 1'b0;
    b_bad      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_len == 11'd0) begin
            start_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            rem_next   = tx_len;
            state_next = S_AW;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_AW: begin
        if (axi_awready) state_next = S_HDR;
        else             state_next = S_AW;
      end
      S_HDR: begin
        if (axi_wready) state_next = S_RD;
        else            state_next = S_HDR;
      end
      S_RD:    state_next = S_RWAIT;
      S_RWAIT: state_next = S_WDAT;
      S_WDAT: begin
        if (axi_wready) begin
          if (beats_left_r == 8'd1) state_next = S_BRESP;
          else                      state_next = S_RD;
        end else begin
          state_next = S_WDAT;
        end
      end
      S_BRESP: begin
        if (axi_bvalid) begin
          if (axi_bresp == 2'b00) begin
            b_ok     = 1'b1;
            // awlen_r holds the payload beat count of the fragment just sent.
            rem_next = remaining_r - {3'b000, awlen_r};
            if (rem_next != 11'd0) state_next = S_AW;
            else                   state_next = S_IDLE;
          end else begin
            b_bad      = 1'b1;
            state_next = S_IDLE;
          end
        end else begin
          state_next = S_BRESP;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (rem_next < MAX_FRAG) frag_next = rem_next[7:0];
    else                     frag_next = MAX_FRAG[7:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_next;
  end

  // Message context, SRAM address and per-fragment beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_r  <= 11'd0;
      addr_r       <= 10'd0;
      beats_left_r <= 8'd0;
      seq_r        <= 2'd0;
      first_r      <= 1'b0;
      tag_r        <= 3'd0;
      to_r         <= 1'b0;
      src_r        <= 8'd0;
      dst_r        <= 8'd0;
    end else begin
      if (start_ok) begin
        remaining_r <= tx_len;
        addr_r      <= tx_base_addr;
        seq_r       <= 2'd0;
        first_r     <= 1'b1;
        tag_r       <= tx_tag;
        to_r        <= tx_to;
        src_r       <= tx_src_id;
        dst_r       <= tx_dst_id;
      end
      if ((state_next == S_AW) && (state_r != S_AW)) beats_left_r <= frag_next;
      // One read per payload beat; the 10-bit address wraps naturally.
      if (state_r == S_RD) addr_r <= addr_r + 10'd1;
      if ((state_r == S_WDAT) && axi_wready) beats_left_r <= beats_left_r - 8'd1;
      if (b_ok) begin
        remaining_r <= rem_next;
        seq_r       <= seq_r + 2'd1;
        first_r     <= 1'b0;
      end
    end
  end

  // Registered interface outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_r <= 1'b0;
      awaddr_r  <= 64'h0;
      awlen_r   <= 8'd0;
      wvalid_r  <= 1'b0;
      wdata_r   <= 256'h0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      ren_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      awvalid_r <= (state_next == S_AW);
      if ((state_next == S_AW) && (state_r != S_AW)) begin
        awaddr_r <= AXI_BASE;
        awlen_r  <= frag_next;
      end
      wvalid_r <= (state_next == S_HDR) || (state_next == S_WDAT);
      if ((state_r == S_AW) && (state_next == S_HDR)) wdata_r <= {224'h0, header};
      if (state_r == S_RWAIT) wdata_r <= sram_rdata;
      wlast_r  <= (state_next == S_WDAT) && (beats_left_r == 8'd1);
      bready_r <= (state_next == S_BRESP);
      ren_r    <= (state_next == S_RD);
      busy_r   <= (state_next != S_IDLE);
      done_r   <= b_ok && (rem_next == 11'd0);
      err_r    <= start_bad || b_bad;
    end
  end

  assign tx_busy     = busy_r;
  assign tx_done     = done_r;
  assign tx_err      = err_r;
  assign sram_ren    = ren_r;
  assign sram_raddr  = addr_r;
  assign axi_awvalid = awvalid_r;
  assign axi_awaddr  = awaddr_r;
  assign axi_awlen   = awlen_r;
  assign axi_awsize  = 3'b101;
  assign axi_awburst = 2'b01;
  assign axi_wvalid  = wvalid_r;
  assign axi_wdata   = wdata_r;
  assign axi_wstrb   = {32{1'b1}};
  assign axi_wlast   = wlast_r;
  assign axi_bready  = bready_r;

endmodule

// File: tb/tb_pcie_msg_transmitter.sv
// Directed bench for pcie_msg_transmitter with an SRAM model, an AXI write
// slave and a monitor that logs AW, W and SRAM read activity.
module tb_pcie_msg_transmitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_start = 1'b0;
  logic [9:0]   tx_base_addr = 10'd0;
  logic [10:0]  tx_len = 11'd0;
  logic [2:0]   tx_tag = 3'd0;
  logic         tx_to = 1'b0;
  logic [7:0]   tx_src_id = 8'd0, tx_dst_id = 8'd0;
  logic         tx_busy, tx_done, tx_err;
  logic         sram_ren;
  logic [9:0]   sram_raddr;
  logic [255:0] sram_rdata = 256'h0;
  logic         axi_awvalid, axi_awready = 1'b1;
  logic [63:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_wvalid, axi_wready = 1'b1;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_bvalid = 1'b0;
  logic [1:0]   axi_bresp = 2'b00;
  logic         axi_bready;
  logic [1:0]   bresp_cfg = 2'b00;

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, aw_hi_cnt = 0, overlap_cnt = 0;
  logic [255:0] wq[$];
  logic         wl[$];
  logic [7:0]   awl[$];
  logic [63:0]  awa[$];
  logic [9:0]   rq[$];
  logic [255:0] st_d;
  logic         st_l;
  int           st_r, st_k;
  int           done_before;

  always #5 clk = ~clk;

  pcie_msg_transmitter dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_base_addr(tx_base_addr),
    .tx_len(tx_len), .tx_tag(tx_tag), .tx_to(tx_to), .tx_src_id(tx_src_id),
    .tx_dst_id(tx_dst_id), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid),
    .axi_bresp(axi_bresp), .axi_bready(axi_bready)
  );

  function automatic logic [255:0] word_of(input logic [9:0] a);
    return {8{22'h2B5A1C, a}};
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (sram_ren) sram_rdata <= word_of(sram_raddr);
  end

  // Write-response channel: answer as soon as bready is seen.
  always @(negedge clk) begin
    axi_bvalid = axi_bready;
    axi_bresp  = bresp_cfg;
  end

  // Monitor: log handshakes, reads and pulses.
  always @(posedge clk) begin
    if (axi_awvalid) aw_hi_cnt++;
    if (axi_awvalid && axi_wvalid) overlap_cnt++;
    if (axi_awvalid && axi_awready) begin awl.push_back(axi_awlen); awa.push_back(axi_awaddr); end
    if (axi_wvalid && axi_wready) begin wq.push_back(axi_wdata); wl.push_back(axi_wlast); end
    if (sram_ren) rq.push_back(sram_raddr);
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
  end

  task automatic clear_log();
    wq.delete(); wl.delete(); awl.delete(); awa.delete(); rq.delete();
    done_cnt = 0; err_cnt = 0; aw_hi_cnt = 0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, sram_ren,
                             tx_busy, tx_done, tx_err}, 8'h00);
    check_eq({tag, "_data"}, {axi_awaddr, axi_awlen, sram_raddr}, 82'h0);
    check_eq({tag, "_wdata"}, axi_wdata, 256'h0);
  endtask

  task automatic run_msg(input logic [9:0] base, input logic [10:0] len, input logic [2:0] tag,
                         input logic to_b, input logic [7:0] src, input logic [7:0] dst);
    int k;
    int ev0;
    @(negedge clk);
    tx_base_addr = base; tx_len = len; tx_tag = tag; tx_to = to_b;
    tx_src_id = src; tx_dst_id = dst; tx_start = 1'b1;
    ev0 = done_cnt + err_cnt;
    @(negedge clk);
    // Change the inputs right away; the message must use the latched values.
    tx_start = 1'b0; tx_base_addr = ~base; tx_len = 11'd7; tx_tag = ~tag;
    tx_to = ~to_b; tx_src_id = ~src; tx_dst_id = ~dst;
    k = 0;
    while ((done_cnt + err_cnt == ev0) && (k < 3000)) begin @(negedge clk); k++; end
    check_eq("completion_timeout", (k < 3000), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Checks the whole logged message against a fragment model built from the spec.
  task automatic check_frags(input string nm, input logic [9:0] base, input int len,
                             input logic [2:0] tag, input logic to_b, input logic [7:0] src,
                             input logic [7:0] dst);
    int nf, rem, flen, idx;
    logic [9:0] a;
    logic [1:0] sq;
    nf = (len + 3) / 4;
    check_eq({nm, "_aw_count"}, awl.size(), nf);
    check_eq({nm, "_w_count"}, wq.size(), len + nf);
    check_eq({nm, "_rd_count"}, rq.size(), len);
    if ((awl.size() == nf) && (wq.size() == len + nf) && (rq.size() == len)) begin
      rem = len; idx = 0; a = base;
      for (int f = 0; f < nf; f++) begin
        flen = (rem < 4) ? rem : 4;
        sq = f[1:0];
        check_eq({nm, "_awlen"}, awl[f], flen[7:0]);
        check_eq({nm, "_awaddr"}, awa[f], 64'h0);
        check_eq({nm, "_hdr"}, wq[idx], {224'h0, (f == 0), (f == nf - 1), sq, to_b, tag, src, dst, 8'h01});
        check_eq({nm, "_hdr_last"}, wl[idx], 1'b0);
        idx++;
        for (int b = 0; b < flen; b++) begin
          check_eq({nm, "_payload"}, wq[idx], word_of(a));
          check_eq({nm, "_wlast"}, wl[idx], (b == flen - 1));
          check_eq({nm, "_raddr"}, rq[idx - f - 1], a);
          idx++; a = a + 10'd1;
        end
        rem = rem - flen;
      end
    end
  endtask

  initial begin
    // Reset state, checked while the clock has not yet risen.
    #3;
    check_quiet("reset");
    check_eq("reset_fixed", {axi_awsize, axi_awburst, axi_wstrb}, {3'b101, 2'b01, 32'hFFFFFFFF});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single fragment message.
    clear_log();
    run_msg(10'h010, 11'd3, 3'd5, 1'b1, 8'h1A, 8'h2B);
    check_frags("one_frag", 10'h010, 3, 3'd5, 1'b1, 8'h1A, 8'h2B);
    if (wq.size() > 0) check_eq("one_frag_hdr_literal", wq[0], 256'hCD1A2B01);
    check_eq("one_frag_done", {done_cnt[7:0], err_cnt[7:0]}, 16'h0100);

    // Three fragments, awlen 4,4,1.
    clear_log();
    run_msg(10'h100, 11'd9, 3'd2, 1'b0, 8'h11, 8'h22);
    check_frags("three_frag", 10'h100, 9, 3'd2, 1'b0, 8'h11, 8'h22);
    if (wq.size() == 12) begin
      check_eq("three_frag_h0", wq[0], 256'h82112201);
      check_eq("three_frag_h1", wq[5], 256'h12112201);
      check_eq("three_frag_h2", wq[10], 256'h62112201);
    end
    check_eq("three_frag_done", done_cnt, 1);

    // wready stall on the first payload beat.
    clear_log();
    fork
      run_msg(10'h020, 11'd3, 3'd1, 1'b0, 8'h05, 8'h06);
      begin
        st_k = 0;
        while ((rq.size() < 1) && (st_k < 500)) begin @(negedge clk); st_k++; end
        axi_wready = 1'b0;
        st_k = 0;
        while (!axi_wvalid && (st_k < 50)) begin @(negedge clk); st_k++; end
        st_d = axi_wdata; st_l = axi_wlast; st_r = rq.size();
        check_eq("stall_first_data", st_d, word_of(10'h020));
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_wdata", axi_wdata, st_d);
          check_eq("stall_wlast", axi_wlast, st_l);
          check_eq("stall_wvalid", axi_wvalid, 1'b1);
        end
        check_eq("stall_no_extra_ren", rq.size(), st_r);
        axi_wready = 1'b1;
      end
    join
    check_frags("stall", 10'h020, 3, 3'd1, 1'b0, 8'h05, 8'h06);

    // Error response on fragment 0 abandons the message.
    clear_log();
    bresp_cfg = 2'b10;
    run_msg(10'h040, 11'd9, 3'd3, 1'b1, 8'h01, 8'h02);
    bresp_cfg = 2'b00;
    check_eq("berr_busy", tx_busy, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("berr_counts", {done_cnt[7:0], err_cnt[7:0]}, 16'h0001);
    check_eq("berr_single_aw", awl.size(), 1);
    check_eq("berr_reads", rq.size(), 4);

    // Zero-length request.
    clear_log();
    run_msg(10'h000, 11'd0, 3'd0, 1'b0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    check_eq("len0_err", err_cnt, 1);
    check_eq("len0_no_aw", aw_hi_cnt, 0);
    check_eq("len0_no_activity", wq.size() + rq.size(), 0);
    check_eq("len0_busy", tx_busy, 1'b0);

    // SRAM address wraps 1023 -> 0.
    clear_log();
    run_msg(10'd1022, 11'd4, 3'd7, 1'b1, 8'hF0, 8'h0F);
    check_frags("wrap", 10'd1022, 4, 3'd7, 1'b1, 8'hF0, 8'h0F);

    // Asynchronous reset during WDAT of fragment 1.
    clear_log();
    fork
      begin
        @(negedge clk);
        tx_base_addr = 10'h200; tx_len = 11'd9; tx_tag = 3'd4; tx_to = 1'b1;
        tx_src_id = 8'hAA; tx_dst_id = 8'hBB; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    st_k = 0;
    while (!((awl.size() == 2) && (rq.size() >= 5) && axi_wvalid) && (st_k < 500)) begin
      @(negedge clk); st_k++;
    end
    check_eq("rst_reached_wdat", (st_k < 500), 1'b1);
    done_before = done_cnt + err_cnt;
    #2 rst_n = 1'b0;
    #1 check_quiet("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midreset_no_pulse", done_cnt + err_cnt, done_before);
    clear_log();
    run_msg(10'h050, 11'd2, 3'd0, 1'b0, 8'h33, 8'h44);
    check_frags("after_reset", 10'h050, 2, 3'd0, 1'b0, 8'h33, 8'h44);
    if (wq.size() > 0) check_eq("after_reset_hdr", wq[0], 256'hC0334401);

    check_eq("aw_w_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
